asconp_iter: RTL

ASCONP_ITER -- requirements
Module: asconp_iter

---
 rtl/asconp_iter_if.sv | 46 ++++
 rtl/asconp_iter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/asconp_iter_if.sv
// Bundle of load, randomness, permutation and result signals for asconp_iter.
// The permutation core itself sits outside the iterator.
//   load    : in_valid_i/in_ready_o, rounds_i, s0_i..s4_i (D*64-bit shared lanes)
//   rdi     : rdi_valid_i/rdi_ready_o, rdi_i
//   perm    : round_cnt_o, perm_rdi_o, px0_o..px4_o -> core, px0_i..px4_i <- core
//   result  : out_valid_o/out_ready_i, s0_o..s4_o
//   status  : busy_o
// The slave modport belongs to the iterator; master is the surrounding environment.
interface asconp_iter_if #(
    parameter int unsigned D        = 2,
    parameter int unsigned RDI_BITS = (D - 1) * D / 2
);
    localparam int unsigned SW = D * 64;

    logic                in_valid_i;
    logic                in_ready_o;
    logic [3:0]          rounds_i;
    logic [SW-1:0]       s0_i, s1_i, s2_i, s3_i, s4_i;
    logic                rdi_valid_i;
    logic                rdi_ready_o;
    logic [RDI_BITS-1:0] rdi_i;
    logic [3:0]          round_cnt_o;
    logic [RDI_BITS-1:0] perm_rdi_o;
    logic [SW-1:0]       px0_o, px1_o, px2_o, px3_o, px4_o;
    logic [SW-1:0]       px0_i, px1_i, px2_i, px3_i, px4_i;
    logic                out_valid_o;
    logic                out_ready_i;
    logic [SW-1:0]       s0_o, s1_o, s2_o, s3_o, s4_o;
    logic                busy_o;

    modport slave (
        input  in_valid_i, rounds_i, s0_i, s1_i, s2_i, s3_i, s4_i,
               rdi_valid_i, rdi_i, px0_i, px1_i, px2_i, px3_i, px4_i, out_ready_i,
        output in_ready_o, rdi_ready_o, round_cnt_o, perm_rdi_o,
               px0_o, px1_o, px2_o, px3_o, px4_o, out_valid_o,
               s0_o, s1_o, s2_o, s3_o, s4_o, busy_o
    );

    modport master (
        output in_valid_i, rounds_i, s0_i, s1_i, s2_i, s3_i, s4_i,
               rdi_valid_i, rdi_i, px0_i, px1_i, px2_i, px3_i, px4_i, out_ready_i,
        input  in_ready_o, rdi_ready_o, round_cnt_o, perm_rdi_o,
               px0_o, px1_o, px2_o, px3_o, px4_o, out_valid_o,
               s0_o, s1_o, s2_o, s3_o, s4_o, busy_o
    );
endinterface

// File: rtl/asconp_iter.sv
// Round iterator around an external masked Ascon permutation round.
// Holds the D-share 5-lane state, issues one round per fresh-randomness
// handshake, waits PERM_LAT cycles for the core, and presents the result.
// Ports: clk, rst (async active-low), bus (asconp_iter_if.slave).
// Parameters: D shares, RDI_BITS randomness width, PERM_LAT core latency (1..3).
// Optional macro ASCONP_ITER_ZEROIZE_EN: clear state and randomness after the
// result handshake and mask s*_o to zero while no result is offered.
module asconp_iter #(
    parameter int unsigned D        = 2,
    parameter int unsigned RDI_BITS = (D - 1) * D / 2,
    parameter int unsigned PERM_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    asconp_iter_if.slave bus
);
    localparam int unsigned SW         = D * 64;
    localparam int unsigned LAT_W      = 2;
    localparam logic [3:0]  MAX_ROUNDS = 4'd12;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    state_e              state_q, state_d;
    logic [4:0][SW-1:0]  lane_q, lane_d, px_in, s_out;
    logic [3:0]          round_cnt_q, round_cnt_d, rounds_eff;
    logic [RDI_BITS-1:0] rdi_q, rdi_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic                in_ready, rdi_ready, out_valid, busy;

    // 0 and anything above 12 both mean a full 12-round permutation
    assign rounds_eff = (bus.rounds_i == 4'd0 || bus.rounds_i > MAX_ROUNDS)
                        ? MAX_ROUNDS : bus.rounds_i;
    assign px_in      = {bus.px4_i, bus.px3_i, bus.px2_i, bus.px1_i, bus.px0_i};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            lane_q      <= '0;
            round_cnt_q <= '0;
            rdi_q       <= '0;
            lat_q       <= '0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            round_cnt_q <= round_cnt_d;
            rdi_q       <= rdi_d;
            lat_q       <= lat_d;
        end
    end

    // Next state, datapath updates and handshake decodes
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        round_cnt_d = round_cnt_q;
        rdi_d       = rdi_q;
        lat_d       = lat_q;
        in_ready    = 1'b0;
        rdi_ready   = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (bus.in_valid_i) begin
                    lane_d      = {bus.s4_i, bus.s3_i, bus.s2_i, bus.s1_i, bus.s0_i};
                    round_cnt_d = rounds_eff;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                rdi_ready = 1'b1;
                if (bus.rdi_valid_i) begin
                    rdi_d   = bus.rdi_i;
                    lat_d   = LAT_W'(PERM_LAT - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // state and randomness stay frozen until the core result is due
                if (lat_q == '0) begin
                    lane_d      = px_in;
                    round_cnt_d = round_cnt_q - 4'd1;
                    state_d     = (round_cnt_q == 4'd1) ? DONE : ISSUE;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready_i) begin
                    state_d = IDLE;
`ifdef ASCONP_ITER_ZEROIZE_EN
                    lane_d = '0;
                    rdi_d  = '0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ASCONP_ITER_ZEROIZE_EN
    assign s_out = (state_q == DONE) ? lane_q : '0;
`else
    assign s_out = lane_q;
`endif

    assign bus.in_ready_o  = in_ready;
    assign bus.rdi_ready_o = rdi_ready;
    assign bus.out_valid_o = out_valid;
    assign bus.busy_o      = busy;
    assign bus.round_cnt_o = round_cnt_q;
    assign bus.perm_rdi_o  = rdi_q;

    assign bus.px0_o = lane_q[0];
    assign bus.px1_o = lane_q[1];
    assign bus.px2_o = lane_q[2];
    assign bus.px3_o = lane_q[3];
    assign bus.px4_o = lane_q[4];

    assign bus.s0_o = s_out[0];
    assign bus.s1_o = s_out[1];
    assign bus.s2_o = s_out[2];
    assign bus.s3_o = s_out[3];
    assign bus.s4_o = s_out[4];
endmodule
